// File: rtl/ifetch_bram_if.sv
// Fetch-stage bus: hazard-unit controls, execute-stage redirect, BRAM port and IF/ID outputs.
interface ifetch_bram_if;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] ALUResultE;
    logic [31:0] ImemAddr;
    logic [31:0] ImemRdata;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    modport slave (
        input  StallF, StallD, FlushD, PCSrcE, PCTargetE, ALUResultE, ImemRdata,
        output ImemAddr, PCF, InstrD, PCD, PCPlus4D, ValidD
    );

    modport master (
        output StallF, StallD, FlushD, PCSrcE, PCTargetE, ALUResultE, ImemRdata,
        input  ImemAddr, PCF, InstrD, PCD, PCPlus4D, ValidD
    );
endinterface

// File: rtl/ifetch_bram.sv
// Instruction fetch with a synchronous-read BRAM and an IF/ID register that can
// hold the BRAM word across stalls.
//   state   | meaning
//   S_EMPTY | bubble in decode, InstrD = NOP_INSTR
//   S_LIVE  | InstrD comes straight from the BRAM read data
//   S_HELD  | stalled, InstrD comes from the hold register
module ifetch_bram #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_bram_if.slave  bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LIVE  = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pcf;
    logic [31:0] r_pcd;
    logic [31:0] r_hold;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_load_pc;
    logic        w_capture_d;
    logic        w_capture_hold;

    assign w_pc_plus4 = r_pcf + 32'd4;
    // A redirect must win over a fetch stall, otherwise the branch is lost.
    assign w_load_pc  = !bus.StallF || bus.PCSrcE[0];

    always_comb begin
        w_pc_next = w_pc_plus4;
        case (bus.PCSrcE)
            2'b01:   w_pc_next = bus.PCTargetE;
            2'b11:   w_pc_next = {bus.ALUResultE[31:1], 1'b0};
            default: w_pc_next = w_pc_plus4;
        endcase
    end

    always_comb begin
        w_state_next   = r_state;
        w_capture_d    = 1'b0;
        w_capture_hold = 1'b0;
        if (bus.FlushD) begin
            w_state_next = S_EMPTY;
        end else if (bus.StallD) begin
            if (r_state == S_LIVE) begin
                w_state_next   = S_HELD;
                w_capture_hold = 1'b1;
            end
        end else begin
            w_state_next = S_LIVE;
            w_capture_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcf  <= RESET_PC;
            r_pcd  <= 32'd0;
            r_hold <= 32'd0;
        end else begin
            if (w_load_pc) begin
                r_pcf <= w_pc_next;
            end
            if (w_capture_d) begin
                r_pcd <= r_pcf;
            end
            if (w_capture_hold) begin
                r_hold <= bus.ImemRdata;
            end
        end
    end

    assign bus.ImemAddr = r_pcf;
    assign bus.PCF      = r_pcf;
    assign bus.PCD      = r_pcd;
    assign bus.PCPlus4D = r_pcd + 32'd4;
    assign bus.ValidD   = (r_state != S_EMPTY);

    always_comb begin
        case (r_state)
            S_LIVE:  bus.InstrD = bus.ImemRdata;
            S_HELD:  bus.InstrD = r_hold;
            default: bus.InstrD = NOP_INSTR;
        endcase
    end

endmodule

// File: doc/ifetch_bram.md
IFETCH_BRAM -- requirements
Module: ifetch_bram

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PCF value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the instruction word driven on InstrD whenever ValidD=0.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be asynchronous, active-high, and clear all state immediately.
REQ-005 StallF  in  1  hold PCF.
REQ-006 StallD  in  1  hold the IF/ID register.
REQ-007 FlushD  in  1  bubble the IF/ID register.
REQ-008 PCSrcE  in  2  bit0 = redirect taken; bit1 = JALR-style target select.
REQ-009 PCTargetE  in  32  branch/JAL target.
REQ-010 ALUResultE  in  32  JALR target.
REQ-011 ImemAddr  out  32  synchronous BRAM read address.
REQ-012 ImemRdata  in  32  BRAM data, valid one cycle after the address.
REQ-013 PCF  out  32  fetch PC.
REQ-014 InstrD  out  32  decode-stage instruction.
REQ-015 PCD  out  32  decode-stage PC.
REQ-016 PCPlus4D  out  32  PCD+4.
REQ-017 ValidD  out  1  InstrD holds a real instruction.

Function
REQ-018 PCNextF SHALL be selected as follows: PCTargetE when PCSrcE=2'b01; {ALUResultE[31:1],1'b0} when PCSrcE=2'b11; otherwise PCF+4, with 32-bit wrap-around (FFFF_FFFC+4=0).
REQ-019 PCF SHALL load PCNextF when StallF=0 or PCSrcE[0]=1; a redirect SHALL override StallF.
REQ-020 ImemAddr SHALL equal PCF combinationally; the BRAM SHALL be read every cycle.
REQ-021 The IF/ID register SHALL capture PCD<=PCF at an edge with FlushD=0 and StallD=0; ImemRdata in the following cycle then SHALL correspond to PCD (1-cycle fetch latency).
REQ-022 The IF/ID register SHALL operate as a 3-state FSM:
- EMPTY: ValidD=0.
- LIVE: ValidD=1, InstrD=ImemRdata.
- HELD: ValidD=1, InstrD=hold register.
REQ-023 Transitions SHALL be evaluated at each edge in priority order:
- FlushD=1 -> EMPTY.
- StallD=1 and LIVE -> HELD, capturing ImemRdata into the hold register.
- StallD=1 and HELD or EMPTY -> no change.
- Otherwise -> LIVE.
REQ-024 FlushD and StallD asserted together SHALL flush: FlushD wins.
REQ-025 While HELD, PCD and the hold register SHALL stay constant regardless of ImemRdata changes.
REQ-026 In EMPTY, InstrD SHALL equal NOP_INSTR and PCD SHALL keep its last value.
REQ-027 PCPlus4D SHALL equal PCD+4 combinationally, with 32-bit wrap-around.
REQ-028 The block SHALL NOT detect hazards itself; StallF/StallD/FlushD timing is owned by the hazard unit.

Reset
REQ-029 On reset assertion, the block SHALL set PCF=RESET_PC, PCD=0, hold register=0, and FSM=EMPTY (ValidD=0, InstrD=NOP_INSTR), without waiting for clk.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard both; the first edge after deassertion SHALL load PCD=RESET_PC with the FSM entering LIVE, and PCF SHALL advance to RESET_PC+4.
REQ-031 While reset is high, the block SHALL ignore all other inputs.

Verification
REQ-032 Sequential fetch: memory[k]=k, reset released, no stalls -> PCF steps 0,4,8,...; from the 2nd edge, InstrD=PCD/4 each cycle with ValidD=1.
REQ-033 Load-use stall: StallF=StallD=1 for 2 cycles while PCD=0x8 -> InstrD stays mem[0x8], PCD=0x8, PCF=0xC throughout, then resumes with PCD=0xC.
REQ-034 Taken branch: PCSrcE=01, PCTargetE=0x40, FlushD=1 at PCF=0x10 -> next cycle PCF=0x40, ValidD=0, InstrD=0x00000013; one cycle later PCD=0x40, InstrD=mem[0x40].
REQ-035 JALR: PCSrcE=11, ALUResultE=0x0000_0105, with StallF=1 in the same cycle -> PCF=0x104; redirect wins over stall.
REQ-036 Flush vs stall: FlushD=StallD=1 in the same cycle -> ValidD=0; the hold register contents are never presented on InstrD.
REQ-037 Async reset pulse between edges while HELD -> ValidD=0 and PCF=RESET_PC immediately; the first fetch after release is at RESET_PC.
